// File: rtl/db_pkg.sv
// Shared constants, pointer-width helper and status type for the data-buffer FIFO.
package db_pkg;

    localparam int DB_DATA_W = 8;
    localparam int DB_DEPTH  = 64;

    function automatic int db_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
        logic underflow;
    } db_status_t;

endpackage

// File: rtl/db_ram.sv
// DEPTH x DATA_W buffer storage: one synchronous write port, one registered read port.
// Only the read register is reset; the array itself carries no reset.
module db_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/db_fifo_param.sv
// Parametrised data-buffer FIFO with internal pointers, sticky error flags and registered read.
// Define DB_PKT_ROLLBACK_EN to enable packet commit/abort of written entries.
module db_fifo_param
    import db_pkg::*;
#(
    parameter int DATA_W = DB_DATA_W,
    parameter int DEPTH  = DB_DEPTH,
    parameter int PTR_W  = db_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              flush,
    input  logic              write_en,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic [PTR_W:0]    buff_occ,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              pkt_commit,
    input  logic              pkt_abort
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;
    logic [PTR_W:0] cptr;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic           read_valid_q;
    logic           clr_any;
    logic           abort_eff;
    logic           wr_acc;
    logic           rd_acc;
    db_status_t     status;

`ifdef DB_PKT_ROLLBACK_EN
    logic [PTR_W:0] cptr_q, cptr_d;

    assign abort_eff = pkt_abort;
    assign cptr      = cptr_q;

    // Commit captures the post-write pointer so a same-cycle write becomes part of the packet.
    always_comb begin
        cptr_d = cptr_q;
        if (clr_any) begin
            cptr_d = '0;
        end else if (pkt_commit && !pkt_abort) begin
            cptr_d = wptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cptr_q <= '0;
        end else begin
            cptr_q <= cptr_d;
        end
    end
`else
    logic unused_pkt;

    assign unused_pkt = pkt_commit | pkt_abort;
    assign abort_eff  = 1'b0;
    assign cptr       = wptr_q;
`endif

    assign status.full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                              (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign status.empty     = (cptr == rptr_q);
    assign status.overflow  = overflow_q;
    assign status.underflow = underflow_q;

    assign clr_any = clear | flush;
    assign wr_acc  = write_en && !status.full && !clr_any && !abort_eff;
    assign rd_acc  = read_en && !status.empty && !clr_any;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_any) begin
            wptr_d = '0;
            rptr_d = '0;
            if (clear) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
        end else begin
            if (abort_eff) begin
                wptr_d = cptr;
            end else if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end else if (write_en) begin
                overflow_d = 1'b1;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + PTR_ONE;
            end else if (read_en) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            read_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            read_valid_q <= rd_acc;
        end
    end

    db_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk    (clk),
        .n_rst  (n_rst),
        .we     (wr_acc),
        .waddr  (wptr_q[PTR_W-1:0]),
        .wdata  (write_data),
        .re     (rd_acc),
        .raddr  (rptr_q[PTR_W-1:0]),
        .rdata  (read_data)
    );

    assign read_valid = read_valid_q;
    assign buff_occ   = wptr_q - rptr_q;
    assign full       = status.full;
    assign empty      = status.empty;
    assign overflow   = status.overflow;
    assign underflow  = status.underflow;

endmodule

// File: tb/tb_db_fifo_param.sv
// Bench for db_fifo_param: directed scenarios plus randomized traffic against a queue model.
module tb_db_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int PW    = 6;
`ifdef DB_PKT_ROLLBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_rst, clear, flush, write_en, read_en, pkt_commit, pkt_abort;
    logic [DW-1:0] write_data, read_data;
    logic          read_valid, full, empty, overflow, underflow;
    logic [PW:0]   buff_occ;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: q holds every written entry in order; the first ncom are readable.
    logic [DW-1:0] q[$];
    int            ncom;
    bit            m_ov, m_un, m_rv;
    logic [DW-1:0] m_rd;

    db_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .flush      (flush),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .read_valid (read_valid),
        .buff_occ   (buff_occ),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .pkt_commit (pkt_commit),
        .pkt_abort  (pkt_abort)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re,
                         input bit cl, input bit fl, input bit cm, input bit ab);
        bit full_m, empty_m;
        write_en = we; write_data = wd; read_en = re;
        clear = cl; flush = fl; pkt_commit = cm; pkt_abort = ab;
        full_m  = (q.size() == DEPTH);
        empty_m = (ncom == 0);
        @(posedge clk); #1;
        write_en = 0; read_en = 0; clear = 0; flush = 0; pkt_commit = 0; pkt_abort = 0;
        m_rv = 0;
        if (cl || fl) begin
            q.delete(); ncom = 0;
            if (cl) begin m_ov = 0; m_un = 0; end
        end else begin
            if (re) begin
                if (!empty_m) begin m_rd = q.pop_front(); m_rv = 1; ncom--; end
                else m_un = 1;
            end
            if (RB && ab) begin
                while (q.size() > ncom) void'(q.pop_back());
            end else if (we) begin
                if (!full_m) q.push_back(wd);
                else m_ov = 1;
            end
            if (!RB || (cm && !ab)) ncom = q.size();
        end
    endtask

    task automatic model_reset();
        q.delete(); ncom = 0; m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic test_reset();
        n_rst = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_tests++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", read_valid); end
        n_tests++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", read_data); end
        n_tests++; if (buff_occ !== 7'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", buff_occ); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags empty %b full %b want 1 0", empty, full); end
        n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err ov %b un %b want 0 0", overflow, underflow); end
        n_rst = 1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hC3;
        for (int i = 0; i < 3; i++) drive(1, exp_d[i], 0, 0, 0, RB, 0);
        n_tests++; if (buff_occ !== 7'd3 || empty !== 1'b0) begin n_fail++; $display("FAIL basic_occ got %0d empty %b want 3 0", buff_occ, empty); end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0, 0, 0, 0);
            n_tests++; if (read_valid !== 1'b1 || read_data !== exp_d[i]) begin n_fail++; $display("FAIL basic_read%0d got v%b %h want v1 %h", i, read_valid, read_data, exp_d[i]); end
            n_tests++; if (int'(buff_occ) !== 2 - i) begin n_fail++; $display("FAIL basic_occ%0d got %0d want %0d", i, buff_occ, 2 - i); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
        drive(0, '0, 0, 0, 0, 0, 0);
        n_tests++; if (read_valid !== 1'b0 || read_data !== 8'hC3) begin n_fail++; $display("FAIL basic_hold got v%b %h want v0 c3", read_valid, read_data); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < DEPTH; i++) drive(1, 8'($urandom), 0, 0, 0, RB, 0);
        n_tests++; if (full !== 1'b1 || int'(buff_occ) !== DEPTH) begin n_fail++; $display("FAIL full_set got full %b occ %0d want 1 64", full, buff_occ); end
        drive(1, 8'hFF, 0, 0, 0, RB, 0);
        n_tests++; if (overflow !== 1'b1 || int'(buff_occ) !== DEPTH || full !== 1'b1) begin n_fail++; $display("FAIL full_ovf got ov %b occ %0d full %b want 1 64 1", overflow, buff_occ, full); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, '0, 1, 0, 0, 0, 0);
            n_tests++; if (read_valid !== 1'b1 || read_data !== m_rd) begin n_fail++; $display("FAIL full_read%0d got v%b %h want v1 %h", i, read_valid, read_data, m_rd); end
        end
        n_tests++; if (empty !== 1'b1 || buff_occ !== 7'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL full_drain got empty %b occ %0d ov %b want 1 0 1", empty, buff_occ, overflow); end
    endtask

    task automatic test_flush_clear();
        for (int i = 0; i < 10; i++) drive(1, 8'(i + 1), 0, 0, 0, RB, 0);
        n_tests++; if (buff_occ !== 7'd10 || overflow !== 1'b1) begin n_fail++; $display("FAIL fl_pre got occ %0d ov %b want 10 1", buff_occ, overflow); end
        drive(1, 8'h77, 1, 0, 1, RB, 0);
        n_tests++; if (buff_occ !== 7'd0 || empty !== 1'b1 || overflow !== 1'b1 || read_valid !== 1'b0) begin n_fail++; $display("FAIL flush got occ %0d empty %b ov %b v%b want 0 1 1 v0", buff_occ, empty, overflow, read_valid); end
        drive(0, '0, 1, 0, 0, 0, 0);
        n_tests++; if (underflow !== 1'b1 || read_valid !== 1'b0) begin n_fail++; $display("FAIL fl_unf got un %b v%b want 1 v0", underflow, read_valid); end
        drive(0, '0, 0, 1, 0, 0, 0);
        n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0 || buff_occ !== 7'd0) begin n_fail++; $display("FAIL clear got ov %b un %b occ %0d want 0 0 0", overflow, underflow, buff_occ); end
    endtask

    task automatic test_simul_empty();
        drive(1, 8'h5A, 1, 0, 0, RB, 0);
        n_tests++; if (underflow !== 1'b1 || read_valid !== 1'b0 || buff_occ !== 7'd1) begin n_fail++; $display("FAIL sim_rw got un %b v%b occ %0d want 1 v0 1", underflow, read_valid, buff_occ); end
        drive(0, '0, 1, 0, 0, 0, 0);
        n_tests++; if (read_valid !== 1'b1 || read_data !== 8'h5A || buff_occ !== 7'd0) begin n_fail++; $display("FAIL sim_read got v%b %h occ %0d want v1 5a 0", read_valid, read_data, buff_occ); end
        drive(0, '0, 0, 1, 0, 0, 0);
    endtask

`ifdef DB_PKT_ROLLBACK_EN
    task automatic test_rollback();
        for (int i = 0; i < 4; i++) drive(1, 8'h10 + 8'(i), 0, 0, 0, 0, 0);
        n_tests++; if (empty !== 1'b1 || buff_occ !== 7'd4) begin n_fail++; $display("FAIL rb_uncommit got empty %b occ %0d want 1 4", empty, buff_occ); end
        drive(0, '0, 0, 0, 0, 1, 0);
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL rb_commit got empty %b want 0", empty); end
        for (int i = 0; i < 3; i++) drive(1, 8'hE0 + 8'(i), 0, 0, 0, 0, 0);
        n_tests++; if (buff_occ !== 7'd7) begin n_fail++; $display("FAIL rb_pre_abort got occ %0d want 7", buff_occ); end
        drive(1, 8'hEE, 0, 0, 0, 1, 1);
        n_tests++; if (buff_occ !== 7'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL rb_abort got occ %0d ov %b want 4 0", buff_occ, overflow); end
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, 0, 0, 0, 0);
            n_tests++; if (read_valid !== 1'b1 || read_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL rb_read%0d got v%b %h want v1 %h", i, read_valid, read_data, 8'h10 + 8'(i)); end
        end
        drive(0, '0, 1, 0, 0, 0, 0);
        n_tests++; if (read_valid !== 1'b0 || underflow !== 1'b1 || buff_occ !== 7'd0) begin n_fail++; $display("FAIL rb_gone got v%b un %b occ %0d want v0 1 0", read_valid, underflow, buff_occ); end
        drive(0, '0, 0, 1, 0, 0, 0);
        drive(1, 8'h31, 0, 0, 0, 0, 0);
        drive(1, 8'h32, 0, 0, 0, 0, 0);
        n_tests++; if (empty !== 1'b1 || buff_occ !== 7'd2) begin n_fail++; $display("FAIL rb2_empty got empty %b occ %0d want 1 2", empty, buff_occ); end
        drive(0, '0, 1, 0, 0, 0, 0);
        n_tests++; if (underflow !== 1'b1 || read_valid !== 1'b0) begin n_fail++; $display("FAIL rb2_unf got un %b v%b want 1 v0", underflow, read_valid); end
        drive(0, '0, 0, 0, 0, 1, 0);
        n_tests++; if (empty !== 1'b0 || buff_occ !== 7'd2) begin n_fail++; $display("FAIL rb2_commit got empty %b occ %0d want 0 2", empty, buff_occ); end
        drive(0, '0, 0, 1, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        int wprob;
        bit we, re, cl, fl, cm, ab;
        for (int i = 0; i < 3000; i++) begin
            wprob = (((i / 300) % 3) == 0) ? 80 : ((((i / 300) % 3) == 1) ? 50 : 20);
            we = ($urandom_range(99) < wprob);
            re = ($urandom_range(99) < (100 - wprob));
            cl = ($urandom_range(499) == 0);
            fl = ($urandom_range(499) == 0);
            cm = RB ? ($urandom_range(3) == 0) : 1'b0;
            ab = RB ? ($urandom_range(29) == 0) : 1'b0;
            drive(we, 8'($urandom), re, cl, fl, cm, ab);
            n_tests++; if (read_valid !== m_rv) begin n_fail++; $display("FAIL rnd_rvalid@%0d got %b want %b", i, read_valid, m_rv); end
            n_tests++; if (read_data !== m_rd) begin n_fail++; $display("FAIL rnd_rdata@%0d got %h want %h", i, read_data, m_rd); end
            n_tests++; if (int'(buff_occ) !== q.size()) begin n_fail++; $display("FAIL rnd_occ@%0d got %0d want %0d", i, buff_occ, q.size()); end
            n_tests++; if (full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full@%0d got %b want %b", i, full, q.size() == DEPTH); end
            n_tests++; if (empty !== (ncom == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d got %b want %b", i, empty, ncom == 0); end
            n_tests++; if (overflow !== m_ov) begin n_fail++; $display("FAIL rnd_ovf@%0d got %b want %b", i, overflow, m_ov); end
            n_tests++; if (underflow !== m_un) begin n_fail++; $display("FAIL rnd_unf@%0d got %b want %b", i, underflow, m_un); end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 8'h40 + 8'(i), 0, 0, 0, RB, 0);
        drive(0, '0, 1, 0, 0, 0, 0);
        n_tests++; if (read_valid !== 1'b1 || read_data !== 8'h40) begin n_fail++; $display("FAIL mid_pre got v%b %h want v1 40", read_valid, read_data); end
        n_rst = 0;
        drive(0, '0, 1, 0, 0, 0, 0);
        model_reset();
        n_tests++; if (read_valid !== 1'b0 || read_data !== 8'h00) begin n_fail++; $display("FAIL mid_rvalid got v%b %h want v0 00", read_valid, read_data); end
        n_tests++; if (buff_occ !== 7'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_ptrs got occ %0d empty %b want 0 1", buff_occ, empty); end
        n_rst = 1;
        drive(1, 8'h99, 0, 0, 0, RB, 0);
        drive(0, '0, 1, 0, 0, 0, 0);
        n_tests++; if (read_valid !== 1'b1 || read_data !== 8'h99) begin n_fail++; $display("FAIL mid_after got v%b %h want v1 99", read_valid, read_data); end
    endtask

    initial begin
        n_rst = 0; clear = 0; flush = 0; write_en = 0; read_en = 0;
        pkt_commit = 0; pkt_abort = 0; write_data = '0;
        model_reset();
        test_reset();
        test_basic();
        test_full_wrap();
        test_flush_clear();
        test_simul_empty();
`ifdef DB_PKT_ROLLBACK_EN
        test_rollback();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
